// File: rtl/dcache_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_controller_pkg
// Description : Shared constants and FSM state encoding for the direct-mapped
//               write-back data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_controller_pkg;

  localparam int NUM_BLOCKS = 8;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam int TAG_W      = 3;
  localparam int INDEX_W    = 3;
  localparam int OFFSET_W   = 2;
  localparam int BLOCK_W    = 32;
  localparam int MEM_ADDR_W = TAG_W + INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_e;

endpackage : dcache_controller_pkg
`default_nettype wire

// File: rtl/dcache_store.sv
`default_nettype none
// ============================================================================
// Module      : dcache_store
// Description : Line storage for the data cache: data, tag, valid and dirty
//               arrays. One shared index serves lookup, byte writes and
//               block fills. Valid/dirty clear asynchronously on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_store
  import dcache_controller_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_W-1:0]    i_index,
  input  logic                  i_byte_we,
  input  logic [OFFSET_W-1:0]   i_offset,
  input  logic [DATA_W-1:0]     i_byte_data,
  input  logic                  i_fill_we,
  input  logic [TAG_W-1:0]      i_fill_tag,
  input  logic [BLOCK_W-1:0]    i_fill_data,
  output logic [BLOCK_W-1:0]    o_data,
  output logic [TAG_W-1:0]      o_tag,
  output logic                  o_valid,
  output logic                  o_dirty
);

  logic [NUM_BLOCKS-1:0][BLOCK_W-1:0] data_q, data_d;
  logic [NUM_BLOCKS-1:0][TAG_W-1:0]   tag_q, tag_d;
  logic [NUM_BLOCKS-1:0]              valid_q, valid_d;
  logic [NUM_BLOCKS-1:0]              dirty_q, dirty_d;

  // Next-state of the arrays: a fill replaces the whole line, otherwise a byte store marks it dirty.
  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (i_fill_we) begin
      data_d[i_index]  = i_fill_data;
      tag_d[i_index]   = i_fill_tag;
      valid_d[i_index] = 1'b1;
      dirty_d[i_index] = 1'b0;
    end else if (i_byte_we) begin
      data_d[i_index][{i_offset, 3'b000} +: DATA_W] = i_byte_data;
      dirty_d[i_index] = 1'b1;
    end
  end

  // Line status bits; reset makes every line invalid and clean at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Data and tag payload carry no reset; they are meaningless until valid is set.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

  assign o_data  = data_q[i_index];
  assign o_tag   = tag_q[i_index];
  assign o_valid = valid_q[i_index];
  assign o_dirty = dirty_q[i_index];

endmodule : dcache_store
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : dcache_controller
// Description : Direct-mapped write-back data cache with miss-handling FSM.
//               Hits complete with no stall; misses stall the CPU while the
//               FSM writes back a dirty victim and refills the line.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_controller
  import dcache_controller_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_W-1:0]     ADDRESS,
  input  logic [DATA_W-1:0]     WRITEDATA,
  output logic [DATA_W-1:0]     READDATA,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]    MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);

  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_W-1:0]    req_index;
  logic [OFFSET_W-1:0]   req_offset;
  logic                  req;
  logic                  hit;

  state_e                state_q, state_d;
  logic                  edge_seen_q, edge_seen_d;
  logic [MEM_ADDR_W-1:0] miss_addr_q, miss_addr_d;

  logic [INDEX_W-1:0]    line_index;
  logic [BLOCK_W-1:0]    line_data;
  logic [TAG_W-1:0]      line_tag;
  logic                  line_valid;
  logic                  line_dirty;
  logic                  byte_we;
  logic                  fill_we;

  assign req_tag    = ADDRESS[ADDR_W-1 -: TAG_W];
  assign req_index  = ADDRESS[OFFSET_W +: INDEX_W];
  assign req_offset = ADDRESS[OFFSET_W-1:0];
  assign req        = READ | WRITE;

  // Lookups follow the CPU address in IDLE; during a miss the captured line
  // address is used so a dropped or changed request cannot corrupt the refill.
  assign line_index = (state_q == IDLE) ? req_index : miss_addr_q[INDEX_W-1:0];

  dcache_store u_store (
    .clk         (CLK),
    .rst         (RESET),
    .i_index     (line_index),
    .i_byte_we   (byte_we),
    .i_offset    (req_offset),
    .i_byte_data (WRITEDATA),
    .i_fill_we   (fill_we),
    .i_fill_tag  (miss_addr_q[MEM_ADDR_W-1 -: TAG_W]),
    .i_fill_data (MEM_READDATA),
    .o_data      (line_data),
    .o_tag       (line_tag),
    .o_valid     (line_valid),
    .o_dirty     (line_dirty)
  );

  assign hit = line_valid && (line_tag == req_tag);

  // Next-state and strobe logic; memory states need at least two edges and
  // leave only on an edge where memory is no longer busy.
  always_comb begin
    state_d     = state_q;
    edge_seen_d = edge_seen_q;
    miss_addr_d = miss_addr_q;
    MEM_READ    = 1'b0;
    MEM_WRITE   = 1'b0;
    byte_we     = 1'b0;
    fill_we     = 1'b0;
    case (state_q)
      IDLE: begin
        edge_seen_d = 1'b0;
        if (req) begin
          if (hit) begin
            byte_we = WRITE;
          end else begin
            miss_addr_d = {req_tag, req_index};
            state_d     = (line_valid && line_dirty) ? WRITEBACK : FETCH;
          end
        end
      end
      WRITEBACK: begin
        MEM_WRITE   = 1'b1;
        edge_seen_d = 1'b1;
        if (edge_seen_q && !MEM_BUSYWAIT) begin
          state_d     = FETCH;
          edge_seen_d = 1'b0;
        end
      end
      FETCH: begin
        MEM_READ    = 1'b1;
        edge_seen_d = 1'b1;
        if (edge_seen_q && !MEM_BUSYWAIT) begin
          state_d     = UPDATE;
          edge_seen_d = 1'b0;
        end
      end
      UPDATE: begin
        fill_we = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM registers; reset aborts any transaction and returns to IDLE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      edge_seen_q <= 1'b0;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      edge_seen_q <= edge_seen_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  // Write-back targets the victim's stored tag; a refill targets the missed tag.
  assign MEM_ADDRESS   = MEM_WRITE ? {line_tag, miss_addr_q[INDEX_W-1:0]} : miss_addr_q;
  assign MEM_WRITEDATA = line_data;

  assign BUSYWAIT = req && !((state_q == IDLE) && hit);
  assign READDATA = RESET ? '0 : line_data[{req_offset, 3'b000} +: DATA_W];

endmodule : dcache_controller
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_controller
// Description : Directed self-checking bench for dcache_controller with a
//               fixed-latency block memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_controller;

  localparam int LAT = 5;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        READ = 1'b0;
  logic        WRITE = 1'b0;
  logic [7:0]  ADDRESS = '0;
  logic [7:0]  WRITEDATA = '0;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  int n_vec = 0;
  int n_fail = 0;

  dcache_controller dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Memory model: unwritten blocks hold byte (byte_address ^ 8'h3C).
  function automatic logic [31:0] default_block(input logic [5:0] a);
    logic [31:0] b;
    for (int k = 0; k < 4; k++) b[k*8 +: 8] = {a, 2'(k)} ^ 8'h3C;
    return b;
  endfunction

  logic [31:0] mem_wr_data [0:63];
  logic [63:0] mem_wr_vld = '0;
  int          mem_cnt = 0;
  logic [31:0] rd_q = '0;

  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mem_cnt < LAT - 1);
  assign MEM_READDATA = rd_q;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mem_cnt <= 0;
    end else if (!(MEM_READ || MEM_WRITE)) begin
      mem_cnt <= 0;
    end else if (mem_cnt == LAT - 1) begin
      mem_cnt <= 0;
      if (MEM_WRITE) begin
        mem_wr_data[MEM_ADDRESS] <= MEM_WRITEDATA;
        mem_wr_vld[MEM_ADDRESS]  <= 1'b1;
      end else begin
        rd_q <= mem_wr_vld[MEM_ADDRESS] ? mem_wr_data[MEM_ADDRESS] : default_block(MEM_ADDRESS);
      end
    end else begin
      mem_cnt <= mem_cnt + 1;
    end
  end

  // Steps edges until BUSYWAIT falls, recording strobe activity.
  task automatic run_miss(output int wb_n, output int fe_n, output int up_n,
                          output logic [5:0] wb_a, output logic [31:0] wb_d,
                          output logic [5:0] fe_a, output logic both, output logic tmo);
    wb_n = 0; fe_n = 0; up_n = 0; wb_a = '0; wb_d = '0; fe_a = '0; both = 1'b0; tmo = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK); #1;
      if (MEM_READ && MEM_WRITE) both = 1'b1;
      if (!BUSYWAIT) begin tmo = 1'b0; break; end
      if (MEM_WRITE) begin wb_n++; wb_a = MEM_ADDRESS; wb_d = MEM_WRITEDATA; end
      else if (MEM_READ) begin fe_n++; fe_a = MEM_ADDRESS; end
      else up_n++;
    end
  endtask

  task automatic test_reset();
    READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h14;
    @(posedge CLK); #1;
    n_vec++; if (READDATA !== 8'h00) begin n_fail++; $display("FAIL reset_readdata: got %h want 00", READDATA); end
    n_vec++; if ({BUSYWAIT, MEM_READ, MEM_WRITE} !== 3'b000) begin n_fail++; $display("FAIL reset_outputs: got %b want 000", {BUSYWAIT, MEM_READ, MEM_WRITE}); end
    RESET = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_clean_read_miss();
    int wb, fe, up; logic [5:0] wa, fa; logic [31:0] wd; logic bo, to;
    READ = 1'b1; ADDRESS = 8'h14; #1;
    n_vec++; if (BUSYWAIT !== 1'b1 || MEM_READ !== 1'b0) begin n_fail++; $display("FAIL miss_immediate_stall: got busy=%b mr=%b want 1 0", BUSYWAIT, MEM_READ); end
    run_miss(wb, fe, up, wa, wd, fa, bo, to);
    n_vec++; if (to || bo) begin n_fail++; $display("FAIL miss1_protocol: got timeout=%b both=%b want 0 0", to, bo); end
    n_vec++; if ({wb, fe, up} !== {32'd0, 32'd5, 32'd1}) begin n_fail++; $display("FAIL miss1_cycles: got wb=%0d fetch=%0d upd=%0d want 0 5 1", wb, fe, up); end
    n_vec++; if (fa !== 6'h05) begin n_fail++; $display("FAIL miss1_fetch_addr: got %h want 05", fa); end
    n_vec++; if (READDATA !== 8'h28) begin n_fail++; $display("FAIL miss1_readdata: got %h want 28", READDATA); end
  endtask

  task automatic test_read_hit();
    ADDRESS = 8'h15; #1;
    n_vec++; if (BUSYWAIT !== 1'b0 || READDATA !== 8'h29) begin n_fail++; $display("FAIL hit_read: got busy=%b data=%h want 0 29", BUSYWAIT, READDATA); end
    @(posedge CLK); #1;
    n_vec++; if ({BUSYWAIT, MEM_READ, MEM_WRITE} !== 3'b000) begin n_fail++; $display("FAIL hit_no_strobe: got %b want 000", {BUSYWAIT, MEM_READ, MEM_WRITE}); end
  endtask

  task automatic test_write_hit();
    READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h16; WRITEDATA = 8'hAB; #1;
    n_vec++; if (BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL write_hit_stall: got %b want 0", BUSYWAIT); end
    @(posedge CLK); #1;
    WRITE = 1'b0; READ = 1'b1; #1;
    n_vec++; if (READDATA !== 8'hAB || BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL write_hit_readback: got %h busy=%b want ab 0", READDATA, BUSYWAIT); end
    ADDRESS = 8'h14; #1;
    n_vec++; if (READDATA !== 8'h28) begin n_fail++; $display("FAIL write_hit_neighbor: got %h want 28", READDATA); end
  endtask

  task automatic test_dirty_evict();
    int wb, fe, up; logic [5:0] wa, fa; logic [31:0] wd; logic bo, to;
    READ = 1'b1; ADDRESS = 8'h34; #1;
    run_miss(wb, fe, up, wa, wd, fa, bo, to);
    n_vec++; if (to || bo) begin n_fail++; $display("FAIL evict_protocol: got timeout=%b both=%b want 0 0", to, bo); end
    n_vec++; if ({wb, fe, up} !== {32'd5, 32'd5, 32'd1}) begin n_fail++; $display("FAIL evict_cycles: got wb=%0d fetch=%0d upd=%0d want 5 5 1", wb, fe, up); end
    n_vec++; if (wa !== 6'h05 || wd !== 32'h2BAB2928) begin n_fail++; $display("FAIL evict_wb: got addr=%h data=%h want 05 2bab2928", wa, wd); end
    n_vec++; if (fa !== 6'h0D || READDATA !== 8'h08) begin n_fail++; $display("FAIL evict_refill: got addr=%h data=%h want 0d 08", fa, READDATA); end
  endtask

  task automatic test_write_miss();
    int wb, fe, up; logic [5:0] wa, fa; logic [31:0] wd; logic bo, to;
    READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h80; WRITEDATA = 8'h5A; #1;
    n_vec++; if (BUSYWAIT !== 1'b1) begin n_fail++; $display("FAIL wmiss_stall: got %b want 1", BUSYWAIT); end
    run_miss(wb, fe, up, wa, wd, fa, bo, to);
    n_vec++; if (to || bo || {wb, fe, up} !== {32'd0, 32'd5, 32'd1} || fa !== 6'h20) begin
      n_fail++; $display("FAIL wmiss_fill: got to=%b both=%b wb=%0d fetch=%0d upd=%0d addr=%h want 0 0 0 5 1 20", to, bo, wb, fe, up, fa); end
    @(posedge CLK); #1;
    WRITE = 1'b0; READ = 1'b1; #1;
    n_vec++; if (READDATA !== 8'h5A) begin n_fail++; $display("FAIL wmiss_byte: got %h want 5a", READDATA); end
    ADDRESS = 8'h81; #1;
    n_vec++; if (READDATA !== 8'hBD) begin n_fail++; $display("FAIL wmiss_neighbor: got %h want bd", READDATA); end
    ADDRESS = 8'h00; #1;
    run_miss(wb, fe, up, wa, wd, fa, bo, to);
    n_vec++; if (to || wb !== 5 || wa !== 6'h20 || wd !== 32'hBFBEBD5A) begin n_fail++; $display("FAIL wmiss_evict: got to=%b wb=%0d addr=%h data=%h want 0 5 20 bfbebd5a", to, wb, wa, wd); end
    n_vec++; if (fa !== 6'h00 || READDATA !== 8'h3C) begin n_fail++; $display("FAIL wmiss_evict_refill: got addr=%h data=%h want 00 3c", fa, READDATA); end
    ADDRESS = 8'h80; #1;
    run_miss(wb, fe, up, wa, wd, fa, bo, to);
    n_vec++; if (to || wb !== 0 || fe !== 5 || READDATA !== 8'h5A) begin n_fail++; $display("FAIL clean_refetch: got to=%b wb=%0d fetch=%0d data=%h want 0 0 5 5a", to, wb, fe, READDATA); end
  endtask

  task automatic test_drop_request();
    int fe;
    READ = 1'b1; ADDRESS = 8'h54; #1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    READ = 1'b0; fe = 2;
    for (int i = 0; i < 50; i++) begin
      @(posedge CLK); #1;
      if (!MEM_READ) break;
      fe++;
    end
    n_vec++; if (fe !== 5 || BUSYWAIT !== 1'b0 || MEM_WRITE !== 1'b0) begin n_fail++; $display("FAIL drop_completes: got fetch=%0d busy=%b mw=%b want 5 0 0", fe, BUSYWAIT, MEM_WRITE); end
    @(posedge CLK); #1;
    READ = 1'b1; #1;
    n_vec++; if (BUSYWAIT !== 1'b0 || READDATA !== 8'h68) begin n_fail++; $display("FAIL drop_line_filled: got busy=%b data=%h want 0 68", BUSYWAIT, READDATA); end
    $display("note: READ and WRITE both asserted (protocol violation), store expected to win");
    WRITE = 1'b1; ADDRESS = 8'h55; WRITEDATA = 8'h77; #1;
    @(posedge CLK); #1;
    WRITE = 1'b0; #1;
    n_vec++; if (READDATA !== 8'h77) begin n_fail++; $display("FAIL priority_write: got %h want 77", READDATA); end
  endtask

  task automatic test_reset_mid_fetch();
    int wb, fe, up; logic [5:0] wa, fa; logic [31:0] wd; logic bo, to;
    READ = 1'b1; ADDRESS = 8'h44; #1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    n_vec++; if (MEM_READ !== 1'b1) begin n_fail++; $display("FAIL rst_fetch_active: got %b want 1", MEM_READ); end
    RESET = 1'b1; #1;
    n_vec++; if ({MEM_READ, MEM_WRITE, BUSYWAIT, READDATA} !== {3'b001, 8'h00}) begin
      n_fail++; $display("FAIL rst_async: got mr=%b mw=%b busy=%b data=%h want 0 0 1 00", MEM_READ, MEM_WRITE, BUSYWAIT, READDATA); end
    #2; RESET = 1'b0; #1;
    run_miss(wb, fe, up, wa, wd, fa, bo, to);
    n_vec++; if (to || wb !== 0 || fe !== 5 || fa !== 6'h11 || READDATA !== 8'h78) begin
      n_fail++; $display("FAIL rst_remiss: got to=%b wb=%0d fetch=%0d addr=%h data=%h want 0 0 5 11 78", to, wb, fe, fa, READDATA); end
    ADDRESS = 8'h14; #1;
    run_miss(wb, fe, up, wa, wd, fa, bo, to);
    n_vec++; if (to || wb !== 0 || fe !== 5 || READDATA !== 8'h28) begin
      n_fail++; $display("FAIL rst_dirty_cleared: got to=%b wb=%0d fetch=%0d data=%h want 0 0 5 28", to, wb, fe, READDATA); end
    READ = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_read_miss();
    test_read_hit();
    test_write_hit();
    test_dirty_evict();
    test_write_miss();
    test_drop_request();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_dcache_controller
`default_nettype wire
